// File: rtl/denormalizer_if.sv
// rtl/denormalizer_if.sv - handshake bundle for the denormalizer input and output streams
interface denormalizer_if #(
    parameter int DATA_W = 16,
    parameter int STEP_W = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [STEP_W-1:0] in_steps;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_ovf;

    // Upstream producer / downstream consumer side
    modport master (
        output in_valid, in_data, in_steps, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    // Denormalizer side
    modport slave (
        input  in_valid, in_data, in_steps, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/denormalizer.sv
// rtl/denormalizer.sv - serial left shifter restoring scale (out = in << steps); DENORM_SATURATE_EN enables saturation
module denormalizer #(
    parameter int DATA_W = 16,
    parameter int STEP_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    denormalizer_if.slave     bus,
    output logic              busy_o
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t            state_q;
    logic [DATA_W-1:0] acc_q;
    logic [STEP_W-1:0] cnt_q;
    logic              ovf_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_ovf_q;
    logic              busy_q;
    logic [DATA_W-1:0] out_data_d;

    // Result presented in DONE: wrapped accumulator, or all ones on overflow when saturating
    always_comb begin
        out_data_d = acc_q;
`ifdef DENORM_SATURATE_EN
        if (ovf_q) begin
            out_data_d = {DATA_W{1'b1}};
        end
`endif
    end

    // Control FSM with registered handshake outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    in_ready_q <= 1'b1;
                    if (bus.in_valid && in_ready_q) begin
                        acc_q      <= bus.in_data;
                        cnt_q      <= bus.in_steps;
                        ovf_q      <= 1'b0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= (bus.in_steps != '0) ? ST_SHIFT : ST_DONE;
                    end
                end
                ST_SHIFT: begin
                    acc_q <= acc_q << 1;
                    cnt_q <= cnt_q - STEP_W'(1);
                    ovf_q <= ovf_q | acc_q[DATA_W-1];
                    if (cnt_q == STEP_W'(1)) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_valid_q && bus.out_ready) begin
                        // Output handshake: release the block; input opens next cycle
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= out_data_d;
                        out_ovf_q   <= ovf_q;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ovf   = out_ovf_q;
    assign busy_o        = busy_q;
endmodule

// File: tb/tb_denormalizer.sv
// tb/tb_denormalizer.sv - randomized self-checking bench for denormalizer against an arithmetic model
module tb_denormalizer;
    localparam int DATA_W = 16;
    localparam int STEP_W = 4;

    logic clk;
    logic rst;
    logic busy;
    int   n_vec;
    int   n_err;

    denormalizer_if #(.DATA_W(DATA_W), .STEP_W(STEP_W)) bus ();

    denormalizer #(.DATA_W(DATA_W), .STEP_W(STEP_W)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus    (bus.slave),
        .busy_o (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: full-precision product of the shift, then wrap or saturate
    function automatic logic [16:0] model(input logic [15:0] data, input logic [3:0] steps);
        logic [31:0] full;
        logic        ovf;
        logic [15:0] res;
        full = {16'h0, data} << steps;
        ovf  = (full[31:16] != 16'h0);
        res  = full[15:0];
`ifdef DENORM_SATURATE_EN
        if (ovf) res = 16'hFFFF;
`endif
        return {ovf, res};
    endfunction

    task automatic run_txn(input logic [15:0] data, input logic [3:0] steps, input int stall);
        logic [16:0] exp;
        int          lat;
        int          busy_cnt;
        int          w;
        exp = model(data, steps);
        w = 0;
        while (bus.in_ready !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        if (w >= 20) begin
            check("in_ready_timeout", 0, 1);
            return;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        bus.in_steps = steps;
        tick();
        bus.in_valid = 1'b0;
        bus.in_data  = 16'($urandom);
        bus.in_steps = 4'($urandom);
        busy_cnt = 0;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) busy_cnt++;
            if (lat == 0) check("in_ready_busy", 32'(bus.in_ready), 0);
            tick();
            lat++;
        end
        check("latency", lat, 32'(steps) + 1);
        for (int i = 0; i < stall; i++) begin
            if (busy === 1'b1) busy_cnt++;
            check("stall_valid", 32'(bus.out_valid), 1);
            check("stall_data", 32'(bus.out_data), 32'(exp[15:0]));
            check("stall_in_ready", 32'(bus.in_ready), 0);
            bus.in_valid = (i == 1);
            bus.in_data  = 16'hDEAD;
            bus.in_steps = 4'd1;
            tick();
            bus.in_valid = 1'b0;
        end
        if (busy === 1'b1) busy_cnt++;
        check("out_data", 32'(bus.out_data), 32'(exp[15:0]));
        check("out_ovf", 32'(bus.out_ovf), 32'(exp[16]));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("valid_drop", 32'(bus.out_valid), 0);
        check("busy_drop", 32'(busy), 0);
        check("busy_cycles", busy_cnt, 32'(steps) + 2 + stall);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_steps  = '0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_out_data", 32'(bus.out_data), 0);
        check("rst_out_ovf", 32'(bus.out_ovf), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_in_ready", 32'(bus.in_ready), 0);
        rst = 1'b0;
        tick();
        check("idle_in_ready", 32'(bus.in_ready), 1);

        run_txn(16'h0001, 4'd15, 0);
        run_txn(16'h00F3, 4'd0, 0);
        run_txn(16'hC001, 4'd2, 0);
        run_txn(16'h8000, 4'd1, 0);
        run_txn(16'h0000, 4'd15, 0);
        run_txn(16'h1234, 4'd3, 5);

        // Abort mid-shift: no result may appear
        while (bus.in_ready !== 1'b1) tick();
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h0003;
        bus.in_steps = 4'd8;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("abort_busy", 32'(busy), 0);
        check("abort_in_ready", 32'(bus.in_ready), 0);
        rst = 1'b0;
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 12; i++) begin
                if (bus.out_valid === 1'b1) seen = 1;
                tick();
            end
            check("abort_no_valid", seen, 0);
        end
        run_txn(16'h0003, 4'd8, 0);

        for (int k = 0; k < 40; k++) begin
            logic [15:0] d;
            d = 16'($urandom);
            if ($urandom_range(0, 7) == 0) d = 16'h0;
            run_txn(d, 4'($urandom), $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
